adder_seq: RTL
==============

ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001 Parameter NIBBLES, default 4, is the number of 4-bit digits per operand; legal range 1..16.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 Port in_valid, input, 1, operand request valid.
REQ-005 Port in_ready, output, 1, block accepts an operand request.
REQ-006 Port a, input, 4*NIBBLES, operand A.
REQ-007 Port b, input, 4*NIBBLES, operand B.
REQ-008 Port c_in, input, 1, carry-in to the least significant nibble.
REQ-009 Port out_valid, output, 1, result valid.
REQ-010 Port out_ready, input, 1, consumer accepts the result.
REQ-011 Port sum, output, 4*NIBBLES, result sum.
REQ-012 Port c_out, output, 1, carry-out of the most significant nibble.
REQ-013 Port add_a, output, 4, nibble of A driven to the external combinational 4-bit adder.
REQ-014 Port add_b, output, 4, nibble of B driven to the external adder.
REQ-015 Port add_c_in, output, 1, carry driven to the external adder.
REQ-016 Port add_sum, input, 4, sum returned by the external adder.
REQ-017 Port add_c_out, input, 1, carry returned by the external adder.

Function
REQ-018 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-019 In IDLE: in_ready=1; in_valid=1 SHALL latch a, b and c_in into internal registers; clear nibble index idx to 0; set the carry register to c_in; go to RUN.
REQ-020 In RUN: add_a=A_reg[4*idx+:4]; add_b=B_reg[4*idx+:4]; add_c_in=carry register.
REQ-021 In RUN, each edge: sum_reg[4*idx+:4] <= add_sum; carry <= add_c_out; idx <= idx+1.
REQ-022 When idx==NIBBLES-1 in RUN, the next edge SHALL store the last nibble, set c_out to add_c_out and go to DONE.
REQ-023 Latency: out_valid SHALL rise exactly NIBBLES cycles after the accepting edge (4 for the default).
REQ-024 In DONE: out_valid=1; sum and c_out stable; held indefinitely while out_ready=0.
REQ-025 out_valid&&out_ready in DONE SHALL return to IDLE; in_ready=1 the following cycle.
REQ-026 Throughput SHALL be one operation per NIBBLES+2 cycles with in_valid and out_ready held high.
REQ-027 Arithmetic: {c_out,sum} SHALL equal a+b+c_in modulo 2^(4*NIBBLES+1).
REQ-028 in_ready SHALL be 0 in RUN and DONE; a, b, c_in and in_valid SHALL be ignored there.
REQ-029 Outside RUN, add_a, add_b and add_c_in SHALL be 0.
REQ-030 sum and c_out SHALL keep their last result in IDLE.
REQ-031 idx SHALL be ceil(log2(NIBBLES+1)) bits wide.
REQ-032 For NIBBLES=1, RUN SHALL last one cycle.

Reset
REQ-033 rst_n=0 SHALL, asynchronously, force state=IDLE, idx=0, carry=0, sum=0, c_out=0, out_valid=0, add_* =0.
REQ-034 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result ever presented.
REQ-035 After rst_n deasserts, in_ready=1 from the first clock cycle.

Verification
REQ-036 a=0xFFFF, b=0x0001, c_in=0 -> after 4 cycles out_valid=1, sum=0x0000, c_out=1.
REQ-037 a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, c_out=0; add_c_in=0 on every nibble cycle after the first.
REQ-038 out_ready=0 for 10 cycles after out_valid -> sum, c_out and out_valid held, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-039 Reset pulse at the 2nd RUN cycle of a=0x8888, b=0x8888 -> all outputs 0 immediately, no out_valid; next request 0x0001+0x0002 -> sum=0x0003.
REQ-040 200 random back-to-back requests with random out_ready -> every result matches a+b+c_in, no loss or duplication, spacing >= 6 cycles.

Source files
------------

// File: rtl/adder_seq.sv
// Multi-cycle adder: walks operands one nibble per clock through an external
// combinational 4-bit adder, rippling the carry through a local register.
module adder_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_c_in,
  input  logic [3:0]           add_sum,
  input  logic                 add_c_out
);

  // state | meaning
  // IDLE  | waiting for a request; last result still presented on sum/c_out
  // RUN   | one nibble per cycle through the external adder, idx selects it
  // DONE  | result valid, held until the consumer takes it

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             c_out_reg;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;

  // Constant-index mux keeps every select in range for any NIBBLES.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  always_comb begin
    add_a    = 4'h0;
    add_b    = 4'h0;
    add_c_in = 1'b0;
    if (state == RUN) begin
      add_a    = a_nib;
      add_b    = b_nib;
      add_c_in = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      c_out_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) sum_reg[4*i +: 4] <= add_sum;
          end
          carry <= add_c_out;
          idx   <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            c_out_reg <= add_c_out;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;

endmodule
